// File: rtl/ikaopll_pg_multislot.sv
// Time-multiplexed OPLL phase generator: one operator slot per enabled cycle,
// two-stage delta/accumulate pipeline over a register-array phase store.
module ikaopll_pg_multislot #(
    parameter int N_SLOTS  = 18,
    parameter int FNUM_W   = 9,
    parameter int PHASE_W  = 19,
    parameter int OUT_W    = 10,
    parameter int MUL_MODE = 0
) (
    input  logic                       i_EMUCLK,
    input  logic                       i_IC,
    input  logic                       i_CEN_n,
    input  logic                       i_SLOT_SYNC,
    input  logic [FNUM_W-1:0]          i_FNUM,
    input  logic [2:0]                 i_BLOCK,
    input  logic [3:0]                 i_MUL,
    input  logic                       i_PM,
    input  logic [2:0]                 i_PMVAL,
    input  logic                       i_PHASE_RST,
    input  logic                       i_HOLD,
    output logic [OUT_W-1:0]           o_OP_PHASE,
    output logic [$clog2(N_SLOTS)-1:0] o_SLOT,
    output logic                       o_VALID
);

    localparam int SLOT_W = $clog2(N_SLOTS);
    localparam int SH_W   = FNUM_W + 7;
    localparam int PROD_W = SH_W + 5;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);

    function automatic logic [4:0] mul_tbl(input logic [3:0] m);
        logic [4:0] f;
        case (m)
            4'd0:    f = 5'd1;
            4'd1:    f = 5'd2;
            4'd2:    f = 5'd4;
            4'd3:    f = 5'd6;
            4'd4:    f = 5'd8;
            4'd5:    f = 5'd10;
            4'd6:    f = 5'd12;
            4'd7:    f = 5'd14;
            4'd8:    f = 5'd16;
            4'd9:    f = 5'd18;
            4'd10:   f = 5'd20;
            4'd11:   f = 5'd20;
            4'd12:   f = 5'd24;
            4'd13:   f = 5'd24;
            default: f = 5'd30;
        endcase
        return f;
    endfunction

    logic                en;
    logic [SLOT_W-1:0]   cnt_q, cnt_d, cur_slot;

    logic [1:0]          pm_amt;
    logic                pm_neg;
    logic [FNUM_W:0]     fnum2, pm_off, base;
    logic [SH_W:0]       base_sh;
    logic [SH_W-1:0]     shifted;
    logic [4:0]          mul_fac;
    logic [PROD_W-1:0]   prod;
    logic [PHASE_W-1:0]  delta_d;

    logic                s1_vld_q;
    logic [SLOT_W-1:0]   s1_slot_q;
    logic [PHASE_W-1:0]  s1_delta_q;
    logic [PHASE_W-1:0]  s1_phase_q;
    logic                s1_rst_q;

    logic [PHASE_W-1:0]  new_phase;
    logic [OUT_W-1:0]    out_phase_d;

    logic [PHASE_W-1:0]  phase_q [N_SLOTS];
    logic [OUT_W-1:0]    out_phase_q;
    logic [SLOT_W-1:0]   out_slot_q;
    logic                out_vld_q;

    assign en = ~i_CEN_n;

    always_comb begin
        cur_slot = i_SLOT_SYNC ? '0 : cnt_q;
        cnt_d    = (cur_slot == LAST_SLOT) ? '0 : cur_slot + SLOT_W'(1);
    end

    always_comb begin
        pm_amt = i_PMVAL[1:0] & {2{i_PM}};
        pm_neg = i_PMVAL[2] & i_PM;
        fnum2  = {i_FNUM, 1'b0};
        case (pm_amt)
            2'd0:    pm_off = '0;
            2'd2:    pm_off = {1'b0, i_FNUM} >> (FNUM_W - 3);
            default: pm_off = {1'b0, i_FNUM} >> (FNUM_W - 2);
        endcase
        // negative offsets clamp at zero; positive ones wrap within FNUM_W+1 bits
        if (pm_neg) begin
            base = (pm_off > fnum2) ? '0 : fnum2 - pm_off;
        end else begin
            base = fnum2 + pm_off;
        end
        base_sh = {7'd0, base} << i_BLOCK;
        shifted = SH_W'(base_sh >> 1);
        mul_fac = (MUL_MODE == 1) ? mul_tbl(i_MUL) : {1'b0, i_MUL};
        prod    = {5'd0, shifted} * {{(PROD_W - 5){1'b0}}, mul_fac};
        if (MUL_MODE == 1) begin
            prod = prod >> 1;
        end
        delta_d = i_HOLD ? '0 : PHASE_W'(prod);
    end

    always_comb begin
        new_phase   = s1_rst_q ? '0 : s1_phase_q + s1_delta_q;
        out_phase_d = OUT_W'(new_phase >> (PHASE_W - OUT_W));
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_IC) begin
            cnt_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_slot_q   <= '0;
            s1_delta_q  <= '0;
            s1_phase_q  <= '0;
            s1_rst_q    <= 1'b0;
            out_phase_q <= '0;
            out_slot_q  <= '0;
            out_vld_q   <= 1'b0;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                phase_q[i] <= '0;
            end
        end else if (en) begin
            cnt_q      <= cnt_d;
            s1_vld_q   <= 1'b1;
            s1_slot_q  <= cur_slot;
            s1_delta_q <= delta_d;
            s1_phase_q <= phase_q[cur_slot];
            s1_rst_q   <= i_PHASE_RST;
            // slot spacing of at least 3 keeps this write clear of the next read of the same slot
            if (s1_vld_q) begin
                phase_q[s1_slot_q] <= new_phase;
                out_phase_q        <= out_phase_d;
                out_slot_q         <= s1_slot_q;
                out_vld_q          <= 1'b1;
            end
        end
    end

    assign o_OP_PHASE = out_phase_q;
    assign o_SLOT     = out_slot_q;
    assign o_VALID    = out_vld_q;

endmodule

// File: tb/tb_ikaopll_pg_multislot.sv
// Self-checking bench: three configurations driven in parallel and compared
// against an arithmetic reference model plus directed constant expectations.
module tb_ikaopll_pg_multislot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       ic, cen_n, sync, pm, prst, hold;
    logic [8:0] fnum;
    logic [2:0] block, pmval;
    logic [3:0] mul;

    logic [9:0]  ph0, ph1;
    logic [11:0] ph2;
    logic [4:0]  sl0, sl1;
    logic [3:0]  sl2;
    logic        v0, v1, v2;

    logic [11:0] act_ph [3];
    logic [4:0]  act_sl [3];
    logic        act_v  [3];

    assign act_ph[0] = {2'b00, ph0};
    assign act_ph[1] = {2'b00, ph1};
    assign act_ph[2] = ph2;
    assign act_sl[0] = sl0;
    assign act_sl[1] = sl1;
    assign act_sl[2] = {1'b0, sl2};
    assign act_v[0]  = v0;
    assign act_v[1]  = v1;
    assign act_v[2]  = v2;

    ikaopll_pg_multislot #(.N_SLOTS(18), .FNUM_W(9), .PHASE_W(19), .OUT_W(10), .MUL_MODE(0)) dut0 (
        .i_EMUCLK(clk), .i_IC(ic), .i_CEN_n(cen_n), .i_SLOT_SYNC(sync), .i_FNUM(fnum),
        .i_BLOCK(block), .i_MUL(mul), .i_PM(pm), .i_PMVAL(pmval), .i_PHASE_RST(prst),
        .i_HOLD(hold), .o_OP_PHASE(ph0), .o_SLOT(sl0), .o_VALID(v0));

    ikaopll_pg_multislot #(.N_SLOTS(18), .FNUM_W(9), .PHASE_W(19), .OUT_W(10), .MUL_MODE(1)) dut1 (
        .i_EMUCLK(clk), .i_IC(ic), .i_CEN_n(cen_n), .i_SLOT_SYNC(sync), .i_FNUM(fnum),
        .i_BLOCK(block), .i_MUL(mul), .i_PM(pm), .i_PMVAL(pmval), .i_PHASE_RST(prst),
        .i_HOLD(hold), .o_OP_PHASE(ph1), .o_SLOT(sl1), .o_VALID(v1));

    ikaopll_pg_multislot #(.N_SLOTS(9), .FNUM_W(9), .PHASE_W(20), .OUT_W(12), .MUL_MODE(0)) dut2 (
        .i_EMUCLK(clk), .i_IC(ic), .i_CEN_n(cen_n), .i_SLOT_SYNC(sync), .i_FNUM(fnum),
        .i_BLOCK(block), .i_MUL(mul), .i_PM(pm), .i_PMVAL(pmval), .i_PHASE_RST(prst),
        .i_HOLD(hold), .o_OP_PHASE(ph2), .o_SLOT(sl2), .o_VALID(v2));

    int n_pass = 0;
    int n_total = 0;

    int CFG_N    [3] = '{18, 18, 9};
    int CFG_PW   [3] = '{19, 19, 20};
    int CFG_OW   [3] = '{10, 10, 12};
    int CFG_MODE [3] = '{0, 1, 0};
    int TBL      [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

    longint m_phase [3][18];
    int     m_cnt [3];
    bit     m_pv  [3];
    int     m_ps  [3];
    longint m_pp  [3];
    bit     m_ov  [3];
    int     m_os  [3];
    longint m_op  [3];

    function automatic longint calc_delta(input int d);
        longint a, off, base, sh, m;
        if (hold) return 0;
        a    = pm ? longint'(pmval[1:0]) : 0;
        off  = (a == 0) ? 0 : (a == 2) ? longint'(fnum) / 64 : longint'(fnum) / 128;
        base = 2 * longint'(fnum) + ((pm && pmval[2]) ? -off : off);
        if (base < 0) base = 0;
        base = base % 1024;
        sh   = (base * (longint'(1) << block)) / 2;
        m    = (CFG_MODE[d] == 1) ? (sh * TBL[mul]) / 2 : sh * longint'(mul);
        return m % (longint'(1) << CFG_PW[d]);
    endfunction

    // Whole-slot behaviour per enabled edge: result computed at once, shown one enabled edge later.
    task automatic model_edge();
        int cur;
        longint np;
        if (ic) begin
            for (int d = 0; d < 3; d++) begin
                m_cnt[d] = 0; m_pv[d] = 0; m_ps[d] = 0; m_pp[d] = 0;
                m_ov[d] = 0; m_os[d] = 0; m_op[d] = 0;
                for (int s = 0; s < 18; s++) m_phase[d][s] = 0;
            end
        end else if (!cen_n) begin
            for (int d = 0; d < 3; d++) begin
                cur = sync ? 0 : m_cnt[d];
                if (m_pv[d]) begin
                    m_ov[d] = 1; m_os[d] = m_ps[d]; m_op[d] = m_pp[d];
                end
                np = prst ? 0 : (m_phase[d][cur] + calc_delta(d)) % (longint'(1) << CFG_PW[d]);
                m_phase[d][cur] = np;
                m_pv[d] = 1;
                m_ps[d] = cur;
                m_pp[d] = np >> (CFG_PW[d] - CFG_OW[d]);
                m_cnt[d] = (cur + 1) % CFG_N[d];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        ic = 1; cen_n = 0; sync = 0; prst = 0; hold = 0; pm = 0; pmval = 0;
        tick();
        ic = 0;
    endtask

    task automatic test_reset();
        ic = 1; cen_n = 1; sync = 0;
        fnum = 9'($urandom); block = 3'($urandom); mul = 4'($urandom);
        tick(); tick();
        for (int d = 0; d < 3; d++) begin
            n_total++;
            if (act_v[d] !== 1'b0 || act_sl[d] !== 5'd0 || act_ph[d] !== 12'd0)
                $display("FAIL reset_dut%0d: got v=%0b slot=%0d ph=%0d, want 0/0/0", d, act_v[d], act_sl[d], act_ph[d]);
            else n_pass++;
        end
        ic = 0;
    endtask

    task automatic test_basic();
        int k;
        do_reset();
        fnum = 256; block = 1; mul = 1; pm = 0; pmval = 0;
        for (int e = 0; e <= 1024 * 18; e++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (act_v[d] !== m_ov[d] || act_sl[d] !== 5'(m_os[d]) || act_ph[d] !== 12'(m_op[d]))
                    $display("FAIL basic_model dut%0d: got v=%0b slot=%0d ph=%0d, want v=%0b slot=%0d ph=%0d",
                             d, act_v[d], act_sl[d], act_ph[d], m_ov[d], m_os[d], m_op[d]);
                else n_pass++;
            end
            if (e >= 1 && (e - 1) % 18 == 0) begin
                k = (e - 1) / 18 + 1;
                n_total++;
                if (sl0 !== 5'd0 || ph0 !== 10'(k % 1024))
                    $display("FAIL basic_pass%0d: got slot=%0d ph=%0d, want slot=0 ph=%0d", k, sl0, ph0, k % 1024);
                else n_pass++;
            end
            if (e >= 1 && (e - 1) % 9 == 0) begin
                k = (e - 1) / 9 + 1;
                n_total++;
                if (sl2 !== 4'd0 || ph2 !== 12'((2 * k) % 4096))
                    $display("FAIL basic_top12_pass%0d: got slot=%0d ph=%0d, want slot=0 ph=%0d", k, sl2, ph2, (2 * k) % 4096);
                else n_pass++;
            end
        end
    endtask

    task automatic test_latency();
        int es;
        do_reset();
        block = 7; mul = 1; pm = 0;
        for (int e = 0; e <= 22; e++) begin
            sync = (e == 0);
            fnum = (e == 5) ? 9'd100 : 9'd0;
            tick();
            if (e >= 1) begin
                es = (e - 1) % 9;
                n_total++;
                if (v0 !== 1'b1 || sl0 !== 5'((e - 1) % 18) || ph0 !== ((e == 6) ? 10'd25 : 10'd0))
                    $display("FAIL latency_dut0 e%0d: got v=%0b slot=%0d ph=%0d, want 1/%0d/%0d",
                             e, v0, sl0, ph0, (e - 1) % 18, (e == 6) ? 25 : 0);
                else n_pass++;
                n_total++;
                if (sl2 !== 4'(es) || ph2 !== ((es == 5) ? 12'd50 : 12'd0))
                    $display("FAIL latency_dut2 e%0d: got slot=%0d ph=%0d, want %0d/%0d", e, sl2, ph2, es, (es == 5) ? 50 : 0);
                else n_pass++;
            end
        end
        sync = 0;
        cen_n = 1;
        for (int i = 0; i < 3; i++) begin
            fnum = 9'($urandom); block = 3'($urandom); mul = 4'($urandom); prst = 1'($urandom);
            tick();
            n_total++;
            if (v0 !== 1'b1 || sl0 !== 5'd3 || ph0 !== 10'd0 || sl2 !== 4'd3)
                $display("FAIL freeze_%0d: got v=%0b slot=%0d ph=%0d slot2=%0d, want 1/3/0/3", i, v0, sl0, ph0, sl2);
            else n_pass++;
        end
        cen_n = 0; prst = 0; fnum = 0;
        tick();
        n_total++;
        if (sl0 !== 5'd4 || sl2 !== 4'd4)
            $display("FAIL freeze_resume: got slot=%0d slot2=%0d, want 4/4", sl0, sl2);
        else n_pass++;
    endtask

    task automatic test_pm();
        int s, os, pass;
        int exp_ph [4] = '{257, 255, 258, 0};
        do_reset();
        block = 1; mul = 1; pm = 1;
        for (int e = 0; e <= 256 * 18; e++) begin
            s = e % 18;
            case (s % 4)
                0: begin fnum = 256; pmval = 1; end
                1: begin fnum = 256; pmval = 5; end
                2: begin fnum = 256; pmval = 2; end
                default: begin fnum = 0; pmval = 6; end
            endcase
            tick();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (act_v[d] !== m_ov[d] || act_sl[d] !== 5'(m_os[d]) || act_ph[d] !== 12'(m_op[d]))
                    $display("FAIL pm_model dut%0d: got v=%0b slot=%0d ph=%0d, want v=%0b slot=%0d ph=%0d",
                             d, act_v[d], act_sl[d], act_ph[d], m_ov[d], m_os[d], m_op[d]);
                else n_pass++;
            end
            if (e >= 1) begin
                os = (e - 1) % 18;
                pass = (e - 1) / 18 + 1;
                if (pass == 256) begin
                    n_total++;
                    if (sl0 !== 5'(os) || ph0 !== 10'(exp_ph[os % 4]))
                        $display("FAIL pm_slot%0d: got slot=%0d ph=%0d, want slot=%0d ph=%0d", os, sl0, ph0, os, exp_ph[os % 4]);
                    else n_pass++;
                end
            end
        end
        pm = 0; pmval = 0;
    endtask

    task automatic test_mul();
        int os, pass, want;
        int mv [3] = '{0, 11, 15};
        int p1 [3] = '{0, 10, 15};
        int p2 [3] = '{1, 20, 30};
        do_reset();
        fnum = 256; block = 1; pm = 0;
        for (int e = 0; e <= 36; e++) begin
            mul = 4'(mv[(e % 18) % 3]);
            tick();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (act_v[d] !== m_ov[d] || act_sl[d] !== 5'(m_os[d]) || act_ph[d] !== 12'(m_op[d]))
                    $display("FAIL mul_model dut%0d: got v=%0b slot=%0d ph=%0d, want v=%0b slot=%0d ph=%0d",
                             d, act_v[d], act_sl[d], act_ph[d], m_ov[d], m_os[d], m_op[d]);
                else n_pass++;
            end
            if (e >= 1) begin
                os = (e - 1) % 18;
                pass = (e - 1) / 18 + 1;
                want = (pass == 1) ? p1[os % 3] : p2[os % 3];
                n_total++;
                if (sl1 !== 5'(os) || ph1 !== 10'(want))
                    $display("FAIL mul_table slot%0d pass%0d: got slot=%0d ph=%0d, want slot=%0d ph=%0d",
                             os, pass, sl1, ph1, os, want);
                else n_pass++;
            end
        end
        mul = 1;
    endtask

    task automatic test_ctrl();
        int s, os, want;
        do_reset();
        fnum = 256; block = 1; mul = 1; pm = 0;
        for (int e = 0; e <= 71; e++) begin
            s = e % 18;
            prst = (e >= 36 && e < 54 && (s == 3 || s == 4));
            hold = (e >= 36 && e < 54 && (s == 4 || s == 5));
            tick();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (act_v[d] !== m_ov[d] || act_sl[d] !== 5'(m_os[d]) || act_ph[d] !== 12'(m_op[d]))
                    $display("FAIL ctrl_model dut%0d: got v=%0b slot=%0d ph=%0d, want v=%0b slot=%0d ph=%0d",
                             d, act_v[d], act_sl[d], act_ph[d], m_ov[d], m_os[d], m_op[d]);
                else n_pass++;
            end
            if (e >= 37 && e <= 54) begin
                os = (e - 1) % 18;
                want = (os == 3 || os == 4) ? 0 : (os == 5) ? 2 : 3;
                n_total++;
                if (sl0 !== 5'(os) || ph0 !== 10'(want))
                    $display("FAIL ctrl_slot%0d: got slot=%0d ph=%0d, want slot=%0d ph=%0d", os, sl0, ph0, os, want);
                else n_pass++;
            end
        end
        prst = 0; hold = 0;
        ic = 1; cen_n = 1;
        tick();
        for (int d = 0; d < 3; d++) begin
            n_total++;
            if (act_v[d] !== 1'b0 || act_sl[d] !== 5'd0 || act_ph[d] !== 12'd0)
                $display("FAIL midreset_dut%0d: got v=%0b slot=%0d ph=%0d, want 0/0/0", d, act_v[d], act_sl[d], act_ph[d]);
            else n_pass++;
        end
        ic = 0; cen_n = 0;
        tick();
        n_total++;
        if (v0 !== 1'b0)
            $display("FAIL midreset_discard: got v=%0b, want 0", v0);
        else n_pass++;
        tick();
        n_total++;
        if (v0 !== 1'b1 || sl0 !== 5'd0 || ph0 !== 10'd1 || ph2 !== 12'd2)
            $display("FAIL midreset_restart: got v=%0b slot=%0d ph=%0d ph2=%0d, want 1/0/1/2", v0, sl0, ph0, ph2);
        else n_pass++;
    endtask

    task automatic test_resync();
        int w0, w2;
        do_reset();
        fnum = 256; block = 1; mul = 1;
        for (int e = 0; e <= 30; e++) begin
            sync = (e == 7);
            tick();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (act_v[d] !== m_ov[d] || act_sl[d] !== 5'(m_os[d]) || act_ph[d] !== 12'(m_op[d]))
                    $display("FAIL resync_model dut%0d: got v=%0b slot=%0d ph=%0d, want v=%0b slot=%0d ph=%0d",
                             d, act_v[d], act_sl[d], act_ph[d], m_ov[d], m_os[d], m_op[d]);
                else n_pass++;
            end
            if (e >= 1) begin
                w0 = (e <= 7) ? e - 1 : (e - 8) % 18;
                w2 = (e <= 7) ? e - 1 : (e - 8) % 9;
                n_total++;
                if (sl0 !== 5'(w0) || sl2 !== 4'(w2))
                    $display("FAIL resync_e%0d: got slot=%0d slot2=%0d, want %0d/%0d", e, sl0, sl2, w0, w2);
                else n_pass++;
            end
        end
        sync = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ic    = ($urandom_range(0, 299) == 0);
            cen_n = ($urandom_range(0, 3) == 0);
            sync  = (m_cnt[0] % 9 != 1) && (m_cnt[0] % 9 != 2) && ($urandom_range(0, 29) == 0);
            fnum  = 9'($urandom);
            block = 3'($urandom);
            mul   = 4'($urandom);
            pm    = 1'($urandom);
            pmval = 3'($urandom);
            prst  = ($urandom_range(0, 15) == 0);
            hold  = ($urandom_range(0, 15) == 0);
            tick();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (act_v[d] !== m_ov[d] || act_sl[d] !== 5'(m_os[d]) || act_ph[d] !== 12'(m_op[d]))
                    $display("FAIL random_model dut%0d i%0d: got v=%0b slot=%0d ph=%0d, want v=%0b slot=%0d ph=%0d",
                             d, i, act_v[d], act_sl[d], act_ph[d], m_ov[d], m_os[d], m_op[d]);
                else n_pass++;
            end
        end
        ic = 0; cen_n = 0; sync = 0; prst = 0; hold = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ic = 1; cen_n = 1; sync = 0; pm = 0; prst = 0; hold = 0;
        fnum = 0; block = 0; pmval = 0; mul = 0;
        test_reset();
        test_basic();
        test_latency();
        test_pm();
        test_mul();
        test_ctrl();
        test_resync();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ikaopll_pg_multislot.md
Name: ikaopll_pg_multislot

Overview:
- Parametrised, time-multiplexed phase generator for the OPLL-family cores. Each enabled cycle serves one operator slot.
- Per-slot datapath: FNUM/BLOCK/MUL/PM delta calculation, then phase accumulation into a register-array phase store.
- Successor to the fixed 18-slot shift-register PG. Adds configurable slot count and widths, a selectable MUL mode, slot-sync realignment and a tagged output.
- Sits between the register/timing block and the operator.

Parameters:
- N_SLOTS, 18, number of time-multiplexed slots; must be at least 3.
- FNUM_W, 9, F-number width.
- PHASE_W, 19, accumulator width per slot.
- OUT_W, 10, output phase width; the top OUT_W bits of the accumulator; must not exceed PHASE_W.
- MUL_MODE, 0, multiplier mode: 0 = raw multiply by MUL; 1 = OPL multiplier table.

Ports:
- i_EMUCLK  in  1  master clock.
- i_IC  in  1  reset; synchronous, active-high.
- i_CEN_n  in  1  clock enable, active-low; all state advances only when it is low.
- i_SLOT_SYNC  in  1  marks the current enabled cycle as slot 0.
- i_FNUM  in  FNUM_W  F-number of the current slot.
- i_BLOCK  in  3  octave of the current slot.
- i_MUL  in  4  multiplier of the current slot.
- i_PM  in  1  phase modulation enable.
- i_PMVAL  in  3  PM value: bit2 = sign (1 = negative), bits1:0 = amount.
- i_PHASE_RST  in  1  clear the current slot's phase.
- i_HOLD  in  1  test freeze: force delta to 0.
- o_OP_PHASE  out  OUT_W  phase output.
- o_SLOT  out  clog2(N_SLOTS)  slot tag for o_OP_PHASE.
- o_VALID  out  1  output valid.

Behaviour:

Reset
- i_IC high on an i_EMUCLK edge acts regardless of i_CEN_n.
- Clears the slot counter, all N_SLOTS phase registers, both pipeline stages, o_OP_PHASE, o_SLOT and o_VALID to 0.
- A reset mid-operation discards in-flight results. The first enabled cycle after reset is slot 0.

Slot counter
- Advances once per enabled cycle and wraps from N_SLOTS-1 to 0.
- i_SLOT_SYNC high forces the current cycle to be treated as slot 0; the next slot is 1.
- i_SLOT_SYNC overrides the counter value; no other state is disturbed.

Stage 1 (enabled cycle in which the slot is current)
- Latch the inputs and compute delta. Read phase[slot].
- PM offset with a = i_PMVAL[1:0] & {2{i_PM}}:
  - a = 0: offset 0.
  - a = 1 or 3: offset = FNUM >> (FNUM_W-2).
  - a = 2: offset = FNUM >> (FNUM_W-3).
- Sign is i_PMVAL[2] & i_PM.
- base = {FNUM,1'b0} ± offset, width FNUM_W+1. A negative result saturates to 0.
- shifted = (base << BLOCK) >> 1, width FNUM_W+7. BLOCK 0 halves base.
- Multiply:
  - MUL_MODE 0: delta = shifted * MUL.
  - MUL_MODE 1: delta = (shifted * T[MUL]) >> 1, with T = 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30.
- delta is truncated to PHASE_W bits.
- i_HOLD forces delta to 0.

Stage 2 (next enabled cycle)
- new = i_PHASE_RST ? 0 : (phase[slot] + delta) mod 2^PHASE_W.
- Write new to phase[slot].
- Register o_OP_PHASE = new[PHASE_W-1 -: OUT_W], o_SLOT = slot, o_VALID = 1.
- i_PHASE_RST takes priority over i_HOLD.

Latency and hazards
- Latency is 2 enabled cycles from slot input to output.
- Outputs hold their values while i_CEN_n is high.
- A slot's read and write never overlap because N_SLOTS >= 3; no bypass logic.
- o_VALID is 0 until the first stage-2 completion after reset, then stays 1.

Test Plan:
- Basic accumulation, defaults, MUL_MODE 0: FNUM=256, BLOCK=1, MUL=1, all other controls 0, all slots.
  - Each pass adds 512 to every slot; o_OP_PHASE = k after k passes.
  - Accumulator wraps to 0 after 1024 passes.
- Latency and tag: pulse i_SLOT_SYNC, then apply FNUM=100 on slot 5 only.
  - o_SLOT=5 two enabled cycles later with o_OP_PHASE reflecting phase 200.
  - Other slots stay 0.
  - Holding i_CEN_n high for 3 cycles mid-stream freezes all outputs.
- Phase modulation: FNUM=256, BLOCK=1, MUL=1, i_PM=1.
  - PMVAL=1 gives delta 514; PMVAL=5 gives 510; PMVAL=2 gives 516.
  - FNUM=0 with PMVAL=6 saturates delta to 0.
- MUL table, MUL_MODE 1: FNUM=256, BLOCK=1.
  - MUL=0 gives delta 256; MUL=11 gives 5120; MUL=15 gives 7680.
- Reset and control priority: accumulate to nonzero phases, then:
  - i_PHASE_RST on slot 3 clears slot 3 only.
  - i_HOLD with i_PHASE_RST still gives 0.
  - i_IC mid-stream gives o_VALID=0, all phases 0, next slot 0.
- Resync and parameters: i_SLOT_SYNC asserted while the counter is at 7 restarts the count at 0.
  - With N_SLOTS=9, PHASE_W=20, OUT_W=12, the counter wraps at 8.
  - Output is the top 12 bits.
